// File: rtl/hpsfpga_spi_pkg.sv
// Shared constants for the HPS-facing SPI master: register map, bit positions
// and shift-engine state encoding.
package hpsfpga_spi_pkg;

    localparam logic [1:0] ADDR_TXDATA  = 2'd0;
    localparam logic [1:0] ADDR_RXDATA  = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_CONTROL = 2'd3;

    localparam int unsigned STAT_BUSY_BIT    = 0;
    localparam int unsigned STAT_DONE_BIT    = 1;
    localparam int unsigned STAT_OVERRUN_BIT = 2;

    localparam int unsigned CTRL_CPOL_BIT   = 16;
    localparam int unsigned CTRL_CPHA_BIT   = 17;
    localparam int unsigned CTRL_IRQ_EN_BIT = 18;
    localparam int unsigned CTRL_CS_SEL_LSB = 24;
    localparam int unsigned CS_SEL_WIDTH    = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD
    } spi_state_t;

endpackage

// File: rtl/hpsfpga_spi_master_if.sv
// Avalon-MM register port of the SPI master, as seen from the lightweight bridge.
interface hpsfpga_spi_master_if;

    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;

    modport master (
        output address,
        output write,
        output writedata,
        output read,
        input  readdata
    );

    modport slave (
        input  address,
        input  write,
        input  writedata,
        input  read,
        output readdata
    );

endinterface

// File: rtl/hpsfpga_spi_shift_engine.sv
// SPI shift engine: half-period divider, edge counter, chip-select sequencing
// and MSB-first transmit/receive shift registers.
module hpsfpga_spi_shift_engine
    import hpsfpga_spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKDIV_WIDTH = 8,
    parameter int unsigned NUM_CS       = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   tx_data,
    input  logic [CLKDIV_WIDTH-1:0] div,
    input  logic                    cpol,
    input  logic                    cpha,
    input  logic [CS_SEL_WIDTH-1:0] cs_sel,
    input  logic                    spi_miso,
    output logic                    busy,
    output logic                    done_pulse,
    output logic [DATA_WIDTH-1:0]   rx_data,
    output logic                    spi_sclk,
    output logic                    spi_mosi,
    output logic [NUM_CS-1:0]       spi_cs_n
);

    localparam int unsigned EDGES = 2 * DATA_WIDTH;
    localparam int unsigned EW    = $clog2(EDGES + 1);

    spi_state_t state_q, state_d;

    logic [CLKDIV_WIDTH-1:0] cnt_q;
    logic [EW-1:0]           edge_q;
    logic [DATA_WIDTH-1:0]   tx_q, rx_q;
    logic                    sclk_q, mosi_q;
    logic [NUM_CS-1:0]       cs_n_q, cs_mask;

    logic step, last, start_ok, issue_edge, odd_edge, sample, drive;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // edge_q counts edges already issued, so the next edge is odd when it is even
    always_comb begin
        state_d    = state_q;
        step       = (cnt_q == '0);
        last       = (edge_q == EW'(EDGES));
        start_ok   = 1'b0;
        issue_edge = 1'b0;
        done_pulse = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    start_ok = 1'b1;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (step) begin
                    issue_edge = 1'b1;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (step) begin
                    if (last) state_d    = ST_HOLD;
                    else      issue_edge = 1'b1;
                end
            end
            ST_HOLD: begin
                if (step) begin
                    done_pulse = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        odd_edge = ~edge_q[0];
        sample   = issue_edge & (cpha ? ~odd_edge : odd_edge);
        drive    = issue_edge & (cpha ? odd_edge : ~odd_edge);
    end

    always_comb begin
        cs_mask = '0;
        for (int unsigned i = 0; i < NUM_CS; i++) begin
            cs_mask[i] = (32'(cs_sel) == i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            edge_q <= '0;
            tx_q   <= '0;
            rx_q   <= '0;
            sclk_q <= 1'b0;
            mosi_q <= 1'b0;
            cs_n_q <= '1;
        end else begin
            if (state_q == ST_IDLE || step) cnt_q <= div;
            else                            cnt_q <= cnt_q - 1'b1;

            if (state_q == ST_IDLE) edge_q <= '0;
            else if (issue_edge)    edge_q <= edge_q + 1'b1;

            // With cpha=0 the first bit must be on MOSI before the first edge
            if (start_ok) begin
                if (!cpha) begin
                    mosi_q <= tx_data[DATA_WIDTH-1];
                    tx_q   <= {tx_data[DATA_WIDTH-2:0], 1'b0};
                end else begin
                    tx_q   <= tx_data;
                end
            end else if (drive) begin
                mosi_q <= tx_q[DATA_WIDTH-1];
                tx_q   <= {tx_q[DATA_WIDTH-2:0], 1'b0};
            end

            if (sample) rx_q <= {rx_q[DATA_WIDTH-2:0], spi_miso};

            if (state_q == ST_IDLE) sclk_q <= cpol;
            else if (issue_edge)    sclk_q <= ~sclk_q;

            if (start_ok)        cs_n_q <= ~cs_mask;
            else if (done_pulse) cs_n_q <= '1;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign rx_data  = rx_q;
    assign spi_sclk = sclk_q;
    assign spi_mosi = mosi_q;
    assign spi_cs_n = cs_n_q;

endmodule

// File: rtl/hpsfpga_spi_master.sv
// Avalon-MM SPI master: register file, read mux and interrupt around the
// shift engine.
module hpsfpga_spi_master
    import hpsfpga_spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKDIV_WIDTH = 8,
    parameter int unsigned NUM_CS       = 2
) (
    input  logic                clk,
    input  logic                reset,
    hpsfpga_spi_master_if.slave avs,
    output logic                irq,
    output logic                spi_sclk,
    output logic                spi_mosi,
    input  logic                spi_miso,
    output logic [NUM_CS-1:0]   spi_cs_n
);

    logic [CLKDIV_WIDTH-1:0] div_q;
    logic                    cpol_q, cpha_q, irq_en_q;
    logic [CS_SEL_WIDTH-1:0] cs_sel_q;
    logic                    done_q, overrun_q;
    logic [DATA_WIDTH-1:0]   rxdata_q;
    logic [31:0]             readdata_q, rd_mux;

    logic                  busy, done_pulse, start;
    logic                  wr_tx, wr_status, wr_ctrl, rd_rx;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  unused_wdata;

    assign wr_tx     = avs.write && (avs.address == ADDR_TXDATA);
    assign wr_status = avs.write && (avs.address == ADDR_STATUS);
    assign wr_ctrl   = avs.write && (avs.address == ADDR_CONTROL);
    assign rd_rx     = avs.read  && (avs.address == ADDR_RXDATA);
    assign start     = wr_tx && !busy;
    assign unused_wdata = ^avs.writedata;

    hpsfpga_spi_shift_engine #(
        .DATA_WIDTH   (DATA_WIDTH),
        .CLKDIV_WIDTH (CLKDIV_WIDTH),
        .NUM_CS       (NUM_CS)
    ) u_engine (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .tx_data    (avs.writedata[DATA_WIDTH-1:0]),
        .div        (div_q),
        .cpol       (cpol_q),
        .cpha       (cpha_q),
        .cs_sel     (cs_sel_q),
        .spi_miso   (spi_miso),
        .busy       (busy),
        .done_pulse (done_pulse),
        .rx_data    (rx_data),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_cs_n   (spi_cs_n)
    );

    // Set conditions take priority over the clearing read/write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q      <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            cs_sel_q   <= '0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            rxdata_q   <= '0;
            readdata_q <= '0;
        end else begin
            if (wr_ctrl && !busy) begin
                div_q    <= avs.writedata[CLKDIV_WIDTH-1:0];
                cpol_q   <= avs.writedata[CTRL_CPOL_BIT];
                cpha_q   <= avs.writedata[CTRL_CPHA_BIT];
                irq_en_q <= avs.writedata[CTRL_IRQ_EN_BIT];
                cs_sel_q <= avs.writedata[CTRL_CS_SEL_LSB +: CS_SEL_WIDTH];
            end

            if (done_pulse) done_q <= 1'b1;
            else if (rd_rx) done_q <= 1'b0;

            if (wr_tx && busy) overrun_q <= 1'b1;
            else if (wr_status && avs.writedata[STAT_OVERRUN_BIT]) overrun_q <= 1'b0;

            if (done_pulse) rxdata_q <= rx_data;

            readdata_q <= rd_mux;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs.address)
            ADDR_RXDATA: rd_mux[DATA_WIDTH-1:0] = rxdata_q;
            ADDR_STATUS: begin
                rd_mux[STAT_BUSY_BIT]    = busy;
                rd_mux[STAT_DONE_BIT]    = done_q;
                rd_mux[STAT_OVERRUN_BIT] = overrun_q;
            end
            ADDR_CONTROL: begin
                rd_mux[CLKDIV_WIDTH-1:0]                    = div_q;
                rd_mux[CTRL_CPOL_BIT]                       = cpol_q;
                rd_mux[CTRL_CPHA_BIT]                       = cpha_q;
                rd_mux[CTRL_IRQ_EN_BIT]                     = irq_en_q;
                rd_mux[CTRL_CS_SEL_LSB +: CS_SEL_WIDTH]     = cs_sel_q;
            end
            default: ;
        endcase
    end

    assign avs.readdata = readdata_q;
    assign irq          = done_q & irq_en_q;

endmodule

// File: tb/tb_hpsfpga_spi_master.sv
// Bench for hpsfpga_spi_master: register reads are scored through an expected
// queue drained by a monitor; pin-level timing is checked directly.
module tb_hpsfpga_spi_master;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       irq, spi_sclk, spi_mosi, spi_miso;
    logic [1:0] spi_cs_n;

    logic       loop_en = 1'b1;
    logic       slave_bit = 1'b0;
    logic [7:0] slave_word = 8'h00;
    int         slave_cnt = 0;
    int         sclk_rises = 0;
    logic       rd_seen = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;
    exp_t sb_q[$];

    hpsfpga_spi_master_if bus();

    hpsfpga_spi_master #(
        .DATA_WIDTH   (8),
        .CLKDIV_WIDTH (8),
        .NUM_CS       (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .avs      (bus),
        .irq      (irq),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .spi_cs_n (spi_cs_n)
    );

    always #5 clk = ~clk;

    assign spi_miso = loop_en ? spi_mosi : slave_bit;

    // Simple SPI slave for cpha=1: presents the next bit on each falling SCLK
    always @(negedge spi_sclk or posedge spi_cs_n[0]) begin
        if (spi_cs_n[0]) begin
            slave_cnt <= 0;
        end else begin
            slave_bit <= slave_word[7 - slave_cnt];
            slave_cnt <= slave_cnt + 1;
        end
    end

    always @(posedge spi_sclk) sclk_rises <= sclk_rises + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) rd_seen <= 1'b0;
        else       rd_seen <= bus.read;
    end

    always @(negedge clk) begin
        if (rd_seen) begin
            if (sb_q.size() == 0) begin
                check("unexpected_read", bus.readdata, 32'hdead_beef);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check(e.name, bus.readdata, e.exp);
            end
        end
    end

    task automatic avs_write(input logic [1:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        bus.address   = addr;
        bus.writedata = data;
        bus.write     = 1'b1;
        @(posedge clk); #1;
        bus.write     = 1'b0;
    endtask

    task automatic avs_read(input logic [1:0] addr, input logic [31:0] exp, input string name);
        exp_t e;
        @(posedge clk); #1;
        bus.address = addr;
        bus.read    = 1'b1;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
        @(posedge clk); #1;
        bus.read    = 1'b0;
    endtask

    // Counts cycles with cs_n[0] low, starting from the cycle after a TXDATA write
    task automatic cs_low_len(input string name, output int n);
        n = 0;
        while (spi_cs_n[0] === 1'b0 && n < 1000) begin
            n++;
            @(posedge clk); #1;
        end
        if (n >= 1000) check({name, "_timeout"}, 32'(n), 32'd0);
    endtask

    int n;
    int base;
    logic cs_bad;

    initial begin
        bus.address   = 2'd0;
        bus.write     = 1'b0;
        bus.writedata = '0;
        bus.read      = 1'b0;

        #12;
        check("rst_readdata", bus.readdata, 32'h0);
        check("rst_cs_n", 32'(spi_cs_n), 32'h3);
        check("rst_sclk", 32'(spi_sclk), 32'h0);
        check("rst_mosi", 32'(spi_mosi), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        avs_read(2'd2, 32'h0, "rst_status");
        avs_read(2'd3, 32'h0, "rst_control");

        // Mode 0, div=1, loopback
        avs_write(2'd3, 32'h0000_0001);
        avs_read(2'd3, 32'h0000_0001, "m0_control");
        base = sclk_rises;
        avs_write(2'd0, 32'h0000_00A5);
        check("m0_cs_n_active", 32'(spi_cs_n), 32'h2);
        cs_low_len("m0", n);
        check("m0_cs_low_cycles", 32'(n), 32'd36);
        check("m0_sclk_rises", 32'(sclk_rises - base), 32'd8);
        avs_read(2'd2, 32'h2, "m0_status");
        avs_read(2'd1, 32'hA5, "m0_rxdata");
        avs_read(2'd2, 32'h0, "m0_status_after_rx");

        // Mode 3, div=3, bench slave returns 0x3C
        loop_en    = 1'b0;
        slave_word = 8'h3C;
        avs_write(2'd3, 32'h0003_0003);
        repeat (2) @(posedge clk); #1;
        check("m3_sclk_idle_high", 32'(spi_sclk), 32'h1);
        base = sclk_rises;
        avs_write(2'd0, 32'h0000_00FF);
        cs_low_len("m3", n);
        check("m3_cs_low_cycles", 32'(n), 32'd72);
        check("m3_sclk_rises", 32'(sclk_rises - base), 32'd8);
        check("m3_sclk_end_high", 32'(spi_sclk), 32'h1);
        avs_read(2'd1, 32'h3C, "m3_rxdata");
        loop_en = 1'b1;

        // Overrun, and CONTROL write ignored while busy
        avs_write(2'd3, 32'h0000_0001);
        avs_write(2'd0, 32'h0000_005A);
        avs_write(2'd3, 32'h0000_0003);
        repeat (6) @(posedge clk);
        avs_write(2'd0, 32'h0000_0033);
        cs_low_len("ovr", n);
        check("ovr_remaining_cycles", 32'(n), 32'd26);
        repeat (4) @(posedge clk); #1;
        check("ovr_no_second_xfer", 32'(spi_cs_n), 32'h3);
        avs_read(2'd2, 32'h6, "ovr_status_set");
        avs_read(2'd3, 32'h1, "ovr_control_kept");
        avs_read(2'd1, 32'h5A, "ovr_rxdata");
        avs_write(2'd2, 32'h0000_0004);
        avs_read(2'd2, 32'h0, "ovr_status_cleared");

        // irq level, clear by RXDATA read, and done-set winning over the read
        avs_write(2'd3, 32'h0004_0001);
        avs_write(2'd0, 32'h0000_0011);
        cs_low_len("irq1", n);
        check("irq_set", 32'(irq), 32'h1);
        avs_read(2'd1, 32'h11, "irq_rxdata1");
        check("irq_cleared", 32'(irq), 32'h0);
        avs_write(2'd0, 32'h0000_0022);
        repeat (34) @(posedge clk);
        avs_read(2'd1, 32'h11, "irq_rx_during_done");
        check("irq_set_wins", 32'(irq), 32'h1);
        check("irq_cs_released", 32'(spi_cs_n), 32'h3);
        avs_read(2'd2, 32'h2, "irq_status_done");
        avs_read(2'd1, 32'h22, "irq_rxdata2");
        check("irq_cleared2", 32'(irq), 32'h0);

        // div=0: one clk per half period
        avs_write(2'd3, 32'h0000_0000);
        avs_write(2'd0, 32'h0000_00C3);
        cs_low_len("div0", n);
        check("div0_cs_low_cycles", 32'(n), 32'd18);
        avs_read(2'd1, 32'hC3, "div0_rxdata");

        // cs_sel beyond NUM_CS: no select, transfer still runs
        avs_write(2'd3, 32'h0500_0001);
        base   = sclk_rises;
        cs_bad = 1'b0;
        avs_write(2'd0, 32'h0000_0081);
        repeat (40) begin
            if (spi_cs_n !== 2'b11) cs_bad = 1'b1;
            @(posedge clk); #1;
        end
        check("cssel_no_cs", 32'(cs_bad), 32'h0);
        check("cssel_sclk_rises", 32'(sclk_rises - base), 32'd8);
        avs_read(2'd2, 32'h2, "cssel_status");
        avs_read(2'd1, 32'h81, "cssel_rxdata");

        // Reset in the middle of a div=1 transfer
        avs_write(2'd3, 32'h0000_0001);
        avs_write(2'd0, 32'h0000_0077);
        repeat (14) @(posedge clk); #1;
        check("mrst_active_before", 32'(spi_cs_n), 32'h2);
        reset = 1'b1;
        #1;
        check("mrst_cs_n", 32'(spi_cs_n), 32'h3);
        check("mrst_sclk", 32'(spi_sclk), 32'h0);
        check("mrst_mosi", 32'(spi_mosi), 32'h0);
        check("mrst_readdata", bus.readdata, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        avs_read(2'd2, 32'h0, "mrst_status");
        avs_read(2'd1, 32'h0, "mrst_rxdata");
        avs_read(2'd3, 32'h0, "mrst_control");
        repeat (40) @(posedge clk); #1;
        check("mrst_stays_idle", 32'(spi_cs_n), 32'h3);

        repeat (3) @(posedge clk); #1;
        if (sb_q.size() != 0) check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/hpsfpga_spi_master.md
Name: hpsfpga_spi_master

Overview:
- Avalon-MM slave SPI master controller. Replaces software bit-banging of the SPI pins through PIO slaves with a hardware shift engine.
- The HPS writes a control word and a transmit byte. The block then sequences chip-select, SCLK and MOSI, samples MISO, and posts the received byte plus a done flag/IRQ.
- Sits on the lightweight HPS-to-FPGA bridge, beside the existing PIO slaves.

Parameters:
- DATA_WIDTH, 8, bits per transfer, MSB first.
- CLKDIV_WIDTH, 8, width of the half-period divider field.
- NUM_CS, 2, number of active-low chip-select outputs (1..8).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- address  in  2  register select
- write  in  1  Avalon write strobe
- writedata  in  32  write data
- read  in  1  Avalon read strobe
- readdata  out  32  registered read data, 1-cycle latency
- irq  out  1  level interrupt = done & irq_en
- spi_sclk  out  1  serial clock
- spi_mosi  out  1  serial data out
- spi_miso  in  1  serial data in
- spi_cs_n  out  NUM_CS  chip selects, active low

Behaviour:
- Register map (word address):
  - 0 TXDATA (W): write starts a transfer.
  - 1 RXDATA (R): last received byte; reading clears done.
  - 2 STATUS (R): bit0 busy, bit1 done (sticky), bit2 overrun (sticky). W: writing 1 to bit2 clears overrun.
  - 3 CONTROL (R/W): [CLKDIV_WIDTH-1:0] div, [16] cpol, [17] cpha, [18] irq_en, [26:24] cs_sel.
- Unused readdata bits read 0. readdata is updated every clk from address (read ignored for the mux, as in the team's PIO slaves).
- Reset values:
  - readdata=0, irq=0, spi_cs_n=all 1, spi_sclk=0, spi_mosi=0.
  - All registers 0, state IDLE.
- Half period H = div+1 clk cycles. A half-period counter reloads on every phase step.
- FSM:
  - IDLE: spi_sclk=cpol, cs all high. A TXDATA write in cycle T latches the shift register. In T+1: busy=1, cs_n[cs_sel]=0, state SETUP. With cpha=0, MOSI is driven with the MSB in T+1.
  - SETUP: wait H → SHIFT.
  - SHIFT: 2*DATA_WIDTH half-periods, SCLK toggling at each boundary.
    - cpha=0: sample MISO on odd (leading) edges; shift MOSI out on even (trailing) edges.
    - cpha=1: drive on leading edges, sample on trailing edges.
    - MISO is sampled on the clk where the edge is issued.
  - After the last edge: HOLD, wait H with SCLK=cpol.
  - HOLD end: cs_n all high, RXDATA loaded, done=1, busy=0 → IDLE.
  - Total transfer = (2*DATA_WIDTH+2)*H cycles from write to done set.
- Boundaries:
  - TXDATA write while busy: ignored, overrun=1.
  - CONTROL write while busy: ignored.
  - cs_sel ≥ NUM_CS: no chip-select asserted, transfer still runs.
  - Done-set and RXDATA read in the same cycle: set wins, done stays 1.
  - Overrun-set and overrun-clear in the same cycle: set wins.
  - div=0 is legal (H=1).
  - Reset asserted mid-transfer: immediate return to reset values; no partial RXDATA update.

Decomposition:
- Shared package hpsfpga_spi_pkg:
  - register address constants;
  - CONTROL/STATUS bit-position constants;
  - FSM state encoding (IDLE, SETUP, SHIFT, HOLD).
- One natural sub-module: hpsfpga_spi_shift_engine (FSM, divider, edge counter, shift registers).
- The top level holds the Avalon register file, read mux and irq.

Test Plan:
- Mode 0, div=1, cs_sel=0, MISO looped to MOSI, write TXDATA=0xA5 → cs_n[0] low 36 cycles, 8 rising SCLK edges, RXDATA=0xA5, STATUS=0x2.
- Mode 3 (cpol=1, cpha=1), div=3, MISO driven with 0x3C by bench slave, TX=0xFF → SCLK idles high, MISO sampled on rising edges, RXDATA=0x3C after 72 cycles.
- TXDATA write 10 cycles into a transfer → first transfer completes unchanged, STATUS bit2=1; write 0x4 to STATUS → bit2=0.
- irq_en=1, complete a transfer → irq=1; read RXDATA → irq=0 the next cycle. Read coinciding with a second done → irq stays 1.
- Reset pulse at cycle 15 of a div=1 transfer → next cycle cs_n=all 1, sclk=0, busy=0, RXDATA unchanged (0).
- cs_sel=5 with NUM_CS=2, TX=0x81 → spi_cs_n stays 2'b11, SCLK still toggles 8 periods, done=1.
